// File: rtl/complex_divider.sv
// Sequential fixed-point complex divider q = (a/b)*2^FRAC_BITS: one multiply stage, then a bit-serial restoring divide.
// Optional macro COMPLEX_DIVIDER_ROUND_EN: extra quotient bit, round half away from zero.
module complex_divider #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned OUTPUT_WIDTH = 18,
  parameter int unsigned FRAC_BITS    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    in_valid,
  output logic                    ready,
  input  logic [DATA_WIDTH-1:0]   a_real,
  input  logic [DATA_WIDTH-1:0]   a_imag,
  input  logic [DATA_WIDTH-1:0]   b_real,
  input  logic [DATA_WIDTH-1:0]   b_imag,
  output logic [OUTPUT_WIDTH-1:0] result_real,
  output logic [OUTPUT_WIDTH-1:0] result_imag,
  output logic                    valid,
  input  logic                    out_ready,
  output logic                    div_by_zero,
  output logic                    saturated
);

  localparam int unsigned PW = 2 * DATA_WIDTH + 1;
`ifdef COMPLEX_DIVIDER_ROUND_EN
  localparam int unsigned ITER = OUTPUT_WIDTH;
  localparam int unsigned RND  = 1;
`else
  localparam int unsigned ITER = OUTPUT_WIDTH - 1;
  localparam int unsigned RND  = 0;
`endif
  localparam int unsigned QW = ITER;
  localparam int unsigned RW = PW + FRAC_BITS + OUTPUT_WIDTH + 1;
  localparam int unsigned CW = $clog2(ITER + 1);
  localparam logic [OUTPUT_WIDTH-1:0] POS_MAX = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
  localparam logic [OUTPUT_WIDTH-1:0] NEG_MIN = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, MULT, CHECK, DIV, DONE} state_t;

  state_t                   state_q, state_d;
  logic signed [DATA_WIDTH-1:0] ar_q, ar_d, ai_q, ai_d, br_q, br_d, bi_q, bi_d;
  logic signed [PW-1:0]     num_re_q, num_re_d, num_im_q, num_im_d;
  logic [PW-1:0]            den_q, den_d;
  logic [RW-1:0]            rem_re_q, rem_re_d, rem_im_q, rem_im_d, dsh_q, dsh_d;
  logic [QW-1:0]            q_re_q, q_re_d, q_im_q, q_im_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     sat_re_q, sat_re_d, sat_im_q, sat_im_d, dbz_q, dbz_d;
  logic [OUTPUT_WIDTH-1:0]  result_real_q, result_real_d, result_imag_q, result_imag_d;
  logic                     valid_q, valid_d, div_by_zero_q, div_by_zero_d;
  logic                     saturated_q, saturated_d;

  function automatic logic [PW-1:0] mag_of(input logic signed [PW-1:0] v);
    return v[PW-1] ? PW'(-v) : PW'(v);
  endfunction

  // Returns {clipped, value}: optional rounding, then saturation and sign.
  function automatic logic [OUTPUT_WIDTH:0] finalize(input logic [QW-1:0] q, input logic neg,
                                                     input logic sat);
    logic [QW:0]             mag;
    logic                    clip;
    logic [OUTPUT_WIDTH-1:0] val;
`ifdef COMPLEX_DIVIDER_ROUND_EN
    mag = ({1'b0, q} + (QW+1)'(1)) >> 1;
`else
    mag = {1'b0, q};
`endif
    clip = sat || (!neg && (mag > (QW+1)'(POS_MAX))) || (neg && (mag > (QW+1)'(NEG_MIN)));
    if (clip) val = neg ? NEG_MIN : POS_MAX;
    else      val = neg ? -OUTPUT_WIDTH'(mag) : OUTPUT_WIDTH'(mag);
    return {clip, val};
  endfunction

  logic [RW-1:0]           n_re_sh, n_im_sh, sat_lim, rem_re_nx, rem_im_nx;
  logic                    ge_re, ge_im;
  logic [QW-1:0]           q_re_nx, q_im_nx;
  logic [OUTPUT_WIDTH:0]   fin_re, fin_im;

  assign n_re_sh   = RW'(mag_of(num_re_q)) << FRAC_BITS;
  assign n_im_sh   = RW'(mag_of(num_im_q)) << FRAC_BITS;
  assign sat_lim   = RW'(den_q) << (OUTPUT_WIDTH - 1);
  assign ge_re     = rem_re_q >= dsh_q;
  assign ge_im     = rem_im_q >= dsh_q;
  assign rem_re_nx = (ge_re ? rem_re_q - dsh_q : rem_re_q) << 1;
  assign rem_im_nx = (ge_im ? rem_im_q - dsh_q : rem_im_q) << 1;
  assign q_re_nx   = {q_re_q[QW-2:0], ge_re};
  assign q_im_nx   = {q_im_q[QW-2:0], ge_im};
  assign fin_re    = finalize(q_re_nx, num_re_q[PW-1], sat_re_q);
  assign fin_im    = finalize(q_im_nx, num_im_q[PW-1], sat_im_q);

  // Acceptance follows enable immediately, so ready is decoded from the state register.
  assign ready       = (state_q == IDLE) && enable && !rst;
  assign result_real = result_real_q;
  assign result_imag = result_imag_q;
  assign valid       = valid_q;
  assign div_by_zero = div_by_zero_q;
  assign saturated   = saturated_q;

  always_comb begin
    state_d = state_q;
    ar_d = ar_q; ai_d = ai_q; br_d = br_q; bi_d = bi_q;
    num_re_d = num_re_q; num_im_d = num_im_q; den_d = den_q;
    rem_re_d = rem_re_q; rem_im_d = rem_im_q; dsh_d = dsh_q;
    q_re_d = q_re_q; q_im_d = q_im_q; cnt_d = cnt_q;
    sat_re_d = sat_re_q; sat_im_d = sat_im_q; dbz_d = dbz_q;
    result_real_d = result_real_q; result_imag_d = result_imag_q;
    valid_d = valid_q; div_by_zero_d = div_by_zero_q; saturated_d = saturated_q;
    if (enable) begin
      case (state_q)
        IDLE: if (in_valid) begin
          ar_d = a_real; ai_d = a_imag; br_d = b_real; bi_d = b_imag;
          state_d = MULT;
        end
        MULT: begin
          num_re_d = PW'(ar_q) * PW'(br_q) + PW'(ai_q) * PW'(bi_q);
          num_im_d = PW'(ai_q) * PW'(br_q) - PW'(ar_q) * PW'(bi_q);
          den_d    = PW'(br_q) * PW'(br_q) + PW'(bi_q) * PW'(bi_q);
          state_d  = CHECK;
        end
        CHECK: begin
          dbz_d    = (den_q == '0);
          sat_re_d = !dbz_d && (n_re_sh >= sat_lim);
          sat_im_d = !dbz_d && (n_im_sh >= sat_lim);
          rem_re_d = n_re_sh << RND;
          rem_im_d = n_im_sh << RND;
          dsh_d    = RW'(den_q) << (ITER - 1);
          q_re_d   = '0;
          q_im_d   = '0;
          cnt_d    = CW'(ITER);
          state_d  = DIV;
        end
        DIV: begin
          rem_re_d = rem_re_nx;
          rem_im_d = rem_im_nx;
          q_re_d   = q_re_nx;
          q_im_d   = q_im_nx;
          cnt_d    = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            result_real_d = dbz_q ? '0 : fin_re[OUTPUT_WIDTH-1:0];
            result_imag_d = dbz_q ? '0 : fin_im[OUTPUT_WIDTH-1:0];
            div_by_zero_d = dbz_q;
            saturated_d   = !dbz_q && (fin_re[OUTPUT_WIDTH] || fin_im[OUTPUT_WIDTH]);
            valid_d       = 1'b1;
            state_d       = DONE;
          end
        end
        DONE: if (out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ar_q <= '0; ai_q <= '0; br_q <= '0; bi_q <= '0;
      num_re_q <= '0; num_im_q <= '0; den_q <= '0;
      rem_re_q <= '0; rem_im_q <= '0; dsh_q <= '0;
      q_re_q <= '0; q_im_q <= '0; cnt_q <= '0;
      sat_re_q <= 1'b0; sat_im_q <= 1'b0; dbz_q <= 1'b0;
      result_real_q <= '0; result_imag_q <= '0;
      valid_q <= 1'b0; div_by_zero_q <= 1'b0; saturated_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ar_q <= ar_d; ai_q <= ai_d; br_q <= br_d; bi_q <= bi_d;
      num_re_q <= num_re_d; num_im_q <= num_im_d; den_q <= den_d;
      rem_re_q <= rem_re_d; rem_im_q <= rem_im_d; dsh_q <= dsh_d;
      q_re_q <= q_re_d; q_im_q <= q_im_d; cnt_q <= cnt_d;
      sat_re_q <= sat_re_d; sat_im_q <= sat_im_d; dbz_q <= dbz_d;
      result_real_q <= result_real_d; result_imag_q <= result_imag_d;
      valid_q <= valid_d; div_by_zero_q <= div_by_zero_d; saturated_q <= saturated_d;
    end
  end

endmodule

// File: tb/tb_complex_divider.sv
// Self-checking bench for complex_divider against an arithmetic reference model.
module tb_complex_divider;

`ifdef COMPLEX_DIVIDER_ROUND_EN
  localparam int LAT = 20;
`else
  localparam int LAT = 19;
`endif
  localparam int POSMAX = 131071;
  localparam int NEGMIN = -131072;

  logic        clk = 1'b0;
  logic        rst, enable, in_valid, out_ready;
  logic        ready, valid, div_by_zero, saturated;
  logic [15:0] a_real, a_imag, b_real, b_imag;
  logic [17:0] result_real, result_imag;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  complex_divider dut (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .ready(ready),
    .a_real(a_real), .a_imag(a_imag), .b_real(b_real), .b_imag(b_imag),
    .result_real(result_real), .result_imag(result_imag), .valid(valid),
    .out_ready(out_ready), .div_by_zero(div_by_zero), .saturated(saturated)
  );

  function automatic int rnd16();
    logic [15:0] v;
    v = 16'($urandom);
    return int'($signed(v));
  endfunction

  // One component: |num|*2^8/den, optional rounding, clipped to 18-bit signed.
  function automatic void comp(input longint n, input longint d, output int q, output bit s);
    bit neg;
    longint m, t, r;
    neg = n < 0;
    m = neg ? -n : n;
    t = (m * 256) / d;
`ifdef COMPLEX_DIVIDER_ROUND_EN
    r = ((m * 512) / d + 1) / 2;
`else
    r = t;
`endif
    s = (t >= 131072) || (!neg && r > 131071);
    if (s) q = neg ? NEGMIN : POSMAX;
    else   q = neg ? -int'(r) : int'(r);
  endfunction

  function automatic void model(input int ar, input int ai, input int br, input int bi,
                                output int er, output int ei, output bit dbz, output bit sat);
    longint nre, nim, den;
    bit s1, s2;
    nre = longint'(ar) * br + longint'(ai) * bi;
    nim = longint'(ai) * br - longint'(ar) * bi;
    den = longint'(br) * br + longint'(bi) * bi;
    if (den == 0) begin
      er = 0; ei = 0; dbz = 1; sat = 0;
    end else begin
      comp(nre, den, er, s1);
      comp(nim, den, ei, s2);
      dbz = 0; sat = s1 | s2;
    end
  endfunction

  task automatic accept(input int ar, input int ai, input int br, input int bi);
    int n = 0;
    while (ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (ready !== 1'b1) begin
      failures++; $display("FAIL accept_wait ready=%b required=1", ready);
    end
    a_real = 16'(ar); a_imag = 16'(ai); b_real = 16'(br); b_imag = 16'(bi);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a_real = 16'($urandom); a_imag = 16'($urandom);
    b_real = 16'($urandom); b_imag = 16'($urandom);
  endtask

  task automatic wait_valid(input int start, output int lat);
    lat = start;
    while (valid !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
    checks++;
    if (valid !== 1'b1) begin
      failures++; $display("FAIL valid_timeout valid=%b required=1", valid);
    end
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready); end
    checks++;
    if ({valid, div_by_zero, saturated} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b exp=000", {valid, div_by_zero, saturated});
    end
    checks++;
    if ({result_real, result_imag} !== 36'd0) begin
      failures++; $display("FAIL reset_result got=%h/%h exp=0/0", result_real, result_imag);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", ready); end
  endtask

  task automatic run_and_check(input string tag, input int ar, input int ai, input int br, input int bi);
    int er, ei, lat;
    bit dbz, sat;
    model(ar, ai, br, bi, er, ei, dbz, sat);
    accept(ar, ai, br, bi);
    wait_valid(0, lat);
    checks++;
    if (lat !== LAT) begin failures++; $display("FAIL %s_latency got=%0d exp=%0d", tag, lat, LAT); end
    checks++;
    if (result_real !== 18'(er) || result_imag !== 18'(ei)) begin
      failures++;
      $display("FAIL %s_result a=(%0d,%0d) b=(%0d,%0d) got=(%0d,%0d) exp=(%0d,%0d)", tag, ar, ai, br, bi,
               $signed(result_real), $signed(result_imag), er, ei);
    end
    checks++;
    if ({div_by_zero, saturated} !== {dbz, sat}) begin
      failures++; $display("FAIL %s_flags got=%b%b exp=%b%b", tag, div_by_zero, saturated, dbz, sat);
    end
    repeat ($urandom_range(0, 2)) @(negedge clk);
    handoff();
    checks++;
    if ({valid, ready} !== 2'b01) begin
      failures++; $display("FAIL %s_handoff valid/ready got=%b exp=01", tag, {valid, ready});
    end
  endtask

  task automatic test_directed();
    int t_ar[8] = '{100, 3, 1, 1, 2, 5, 32767, -32768};
    int t_ai[8] = '{0, 4, 0, 0, 0, -7, 0, 0};
    int t_br[8] = '{100, 1, 2, 3, 3, 0, 1, 1};
    int t_bi[8] = '{0, 2, 1, 0, 0, 0, 0, 0};
    for (int i = 0; i < 8; i++) run_and_check("directed", t_ar[i], t_ai[i], t_br[i], t_bi[i]);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      int ar, ai, br, bi, sel;
      ar = rnd16(); ai = rnd16(); br = rnd16(); bi = rnd16();
      sel = int'($urandom_range(0, 7));
      if (sel < 2) begin br = int'($urandom_range(0, 16)) - 8; bi = int'($urandom_range(0, 16)) - 8; end
      else if (sel == 2) begin br = 0; bi = 0; end
      else if (sel == 3) begin ar = ar / 512; ai = ai / 512; end
      run_and_check("random", ar, ai, br, bi);
    end
  endtask

  task automatic test_backpressure();
    int lat, er, ei, nbad;
    bit dbz, sat;
    logic [17:0] sr, si;
    accept(3, 4, 1, 2);
    wait_valid(0, lat);
    sr = result_real; si = result_imag;
    nbad = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      a_real = 16'($urandom); b_real = 16'($urandom);
      @(negedge clk);
      if ({valid, ready, result_real, result_imag} !== {1'b1, 1'b0, sr, si}) nbad++;
    end
    in_valid = 1'b0;
    checks++;
    if (nbad != 0) begin failures++; $display("FAIL backpressure_hold bad_cycles=%0d exp=0", nbad); end
    model(3, 4, 1, 2, er, ei, dbz, sat);
    checks++;
    if (sr !== 18'(er) || si !== 18'(ei)) begin
      failures++; $display("FAIL backpressure_result got=(%0d,%0d) exp=(%0d,%0d)", $signed(sr), $signed(si), er, ei);
    end
    handoff();
    checks++;
    if ({valid, ready} !== 2'b01) begin
      failures++; $display("FAIL backpressure_release valid/ready got=%b exp=01", {valid, ready});
    end
    run_and_check("after_bp", 2, 0, 3, 0);
  endtask

  task automatic test_reset_mid();
    int rose = 0;
    accept(100, 0, 100, 0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({valid, div_by_zero, saturated, result_real, result_imag} !== 39'd0 || ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid outputs valid=%b dbz=%b sat=%b res=%h/%h ready=%b exp=0,0,0,0/0,1",
               valid, div_by_zero, saturated, result_real, result_imag, ready);
    end
    repeat (25) begin @(negedge clk); if (valid === 1'b1) rose++; end
    checks++;
    if (rose != 0) begin failures++; $display("FAIL reset_mid_no_result valid_cycles=%0d exp=0", rose); end
  endtask

  task automatic test_enable_stall();
    int lat, er, ei;
    bit dbz, sat;
    model(1000, -2000, 300, 77, er, ei, dbz, sat);
    accept(1000, -2000, 300, 77);
    repeat (6) @(negedge clk);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    enable = 1'b1;
    wait_valid(11, lat);
    checks++;
    if (lat !== LAT + 5) begin failures++; $display("FAIL stall_latency got=%0d exp=%0d", lat, LAT + 5); end
    checks++;
    if (result_real !== 18'(er) || result_imag !== 18'(ei) || {div_by_zero, saturated} !== {dbz, sat}) begin
      failures++;
      $display("FAIL stall_result got=(%0d,%0d) exp=(%0d,%0d)", $signed(result_real), $signed(result_imag), er, ei);
    end
    enable = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    enable = 1'b1;
    checks++;
    if (valid !== 1'b1) begin failures++; $display("FAIL stall_out_ready_ignored valid=%b exp=1", valid); end
    handoff();
    checks++;
    if ({valid, ready} !== 2'b01) begin
      failures++; $display("FAIL stall_handoff valid/ready got=%b exp=01", {valid, ready});
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_real = '0; a_imag = '0; b_real = '0; b_imag = '0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_enable_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
